post_strip: RTL
===============

POST_STRIP -- requirements
Module: post_strip

Interface
REQ-001 Parameter SEQ_INIT, 16'h0001, expected sequence number of the first frame after reset.
REQ-002 s_axis_aclk  input  1  sole clock; all state rises on its posedge.
REQ-003 s_axis_aresetn  input  1  reset, asynchronous assert, active-low.
REQ-004 s_axis_tvalid / s_axis_tdata / s_axis_tlast  input  1/32/1  AXI-Stream slave from Aurora; the tlast word of each frame carries the sequence number in [15:0].
REQ-005 s_axis_tready  output  1  slave ready.
REQ-006 m_axis_tvalid / m_axis_tdata / m_axis_tlast  output  1/32/1  AXI-Stream master toward the user side.
REQ-007 m_axis_tready  input  1  master ready.
REQ-008 ctrl_strip_seq_en  input  1  1 = strip and check the sequence word; 0 = pass through.
REQ-009 ctrl_rst_cntr_in  input  1  level; clears the status counters while high.
REQ-010 slv_cntr_in  output  64  count of received frames.
REQ-011 slv_seq_err  output  32  count of sequence mismatches.
REQ-012 slv_seq_last  output  16  last received sequence number.
REQ-013 seq_err  output  1  one-cycle pulse per mismatch.

Function
REQ-014 Input beat accepted iff s_axis_tvalid && s_axis_tready; s_axis_tready = !m_axis_tvalid || m_axis_tready; no combinational path from s_axis_tvalid to s_axis_tready.
REQ-015 Output register (m_axis_*) holds its value while m_axis_tvalid && !m_axis_tready; it clears m_axis_tvalid after a handshake unless reloaded in the same cycle.
REQ-016 Mode is latched from ctrl_strip_seq_en on the first accepted beat of each frame; changes mid-frame take effect on the next frame.
REQ-017 Pass mode: each accepted beat is loaded into the output register with its own tlast; latency is 1 cycle; no sequence check.
REQ-018 Strip mode uses a one-word hold register (hold_data, hold_valid).
REQ-019 Strip mode, accepted non-last beat: if hold_valid, move hold into the output register with tlast=0; load the new beat into hold; set hold_valid=1.
REQ-020 Strip mode, accepted last beat (sequence word): if hold_valid, move hold into the output register with tlast=1 and set hold_valid=0; the sequence word is never forwarded.
REQ-021 Strip mode, single-beat frame (hold empty at tlast): no output beat; frame is still counted and checked.
REQ-022 Data latency in strip mode: a word appears on m_axis 1 cycle after the following input beat is accepted.
REQ-023 Sequence check states: UNSYNC, SYNC; reset and counter-reset enter UNSYNC with expected=SEQ_INIT.
REQ-024 On each strip-mode tlast beat: slv_seq_last <= tdata[15:0]; expected <= tdata[15:0]+1 (16-bit wrap, 16'hFFFF -> 16'h0000); UNSYNC -> SYNC with no error check on the first frame after counter reset; in SYNC, tdata[15:0] != expected pulses seq_err for 1 cycle and increments slv_seq_err (saturates at 32'hFFFFFFFF).
REQ-025 tdata[31:16] of the sequence word is ignored.
REQ-026 slv_cntr_in increments by 1 on every accepted tlast beat in either mode, wrapping modulo 2^64.
REQ-027 Counter states: CNT_COUNT, CNT_RST; ctrl_rst_cntr_in=1 zeros slv_cntr_in, slv_seq_err, slv_seq_last and enters CNT_RST; CNT_RST ignores frame events and returns to CNT_COUNT on ctrl_rst_cntr_in=0; datapath unaffected.
REQ-028 Counter reset and tlast in the same cycle: reset wins; the frame is not counted.

Reset
REQ-029 s_axis_aresetn=0 asynchronously forces m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, hold_valid=0, seq_err=0, all counters 0, expected=SEQ_INIT, UNSYNC, CNT_COUNT.
REQ-030 s_axis_tready=1 during and after reset; a frame interrupted by reset is discarded, and the next accepted beat starts a new frame.

Verification
REQ-031 Strip, m_axis_tready=1, frame A,B,C,seq 0x0001 -> output A,B,C with tlast on C; slv_cntr_in=1; slv_seq_last=0x0001; slv_seq_err=0.
REQ-032 Strip, frames with seq 0x0001, 0x0002, 0x0005 -> one seq_err pulse; slv_seq_err=1; the next frame with seq 0x0006 produces no error.
REQ-033 Strip, seq 0xFFFF then 0x0000 -> no error; then 0x0001 after counter reset -> no error (UNSYNC).
REQ-034 m_axis_tready toggled randomly over 100 frames -> no beat lost or duplicated; m_axis_* stable while stalled.
REQ-035 Single-beat frame in strip mode -> no output; slv_cntr_in=1. Pass mode, frame X,Y -> X,Y output, tlast on Y.
REQ-036 ctrl_rst_cntr_in held high across 2 frames -> counters stay 0 and data still flows; after deassertion the next frame gives slv_cntr_in=1.

Source files
------------

// File: rtl/post_strip.sv
// rtl/post_strip.sv - Aurora frame post-processor: strips the trailing sequence word,
// checks sequence continuity and keeps frame/error status counters.
module post_strip #(
   parameter logic [15:0] SEQ_INIT = 16'h0001
) (
   input  logic        s_axis_aclk,
   input  logic        s_axis_aresetn,
   input  logic        s_axis_tvalid,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready,
   output logic        m_axis_tvalid,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   input  logic        ctrl_strip_seq_en,
   input  logic        ctrl_rst_cntr_in,
   output logic [63:0] slv_cntr_in,
   output logic [31:0] slv_seq_err,
   output logic [15:0] slv_seq_last,
   output logic        seq_err
);
   typedef enum logic { UNSYNC, SYNC } seq_state_t;
   typedef enum logic { CNT_COUNT, CNT_RST } cnt_state_t;

   seq_state_t  seq_state_q, seq_state_d;
   cnt_state_t  cnt_state_q, cnt_state_d;
   logic        m_valid_q, m_valid_d;
   logic [31:0] m_data_q, m_data_d;
   logic        m_last_q, m_last_d;
   logic [31:0] hold_data_q, hold_data_d;
   logic        hold_valid_q, hold_valid_d;
   logic        in_frame_q, in_frame_d;
   logic        mode_q, mode_d;
   logic [15:0] expected_q, expected_d;
   logic [15:0] seq_last_q, seq_last_d;
   logic [63:0] cntr_q, cntr_d;
   logic [31:0] err_cnt_q, err_cnt_d;
   logic        seq_err_q, seq_err_d;
   logic        accept;
   logic        strip;

   assign s_axis_tready = !m_valid_q || m_axis_tready;
   assign accept        = s_axis_tvalid && s_axis_tready;
   // Mode is sampled live only on the first beat of a frame, latched afterwards.
   assign strip         = in_frame_q ? mode_q : ctrl_strip_seq_en;

   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tlast  = m_last_q;
   assign slv_cntr_in   = cntr_q;
   assign slv_seq_err   = err_cnt_q;
   assign slv_seq_last  = seq_last_q;
   assign seq_err       = seq_err_q;

   always_comb begin
      m_valid_d    = m_valid_q;
      m_data_d     = m_data_q;
      m_last_d     = m_last_q;
      hold_data_d  = hold_data_q;
      hold_valid_d = hold_valid_q;
      in_frame_d   = in_frame_q;
      mode_d       = mode_q;
      seq_state_d  = seq_state_q;
      cnt_state_d  = cnt_state_q;
      expected_d   = expected_q;
      seq_last_d   = seq_last_q;
      cntr_d       = cntr_q;
      err_cnt_d    = err_cnt_q;
      seq_err_d    = 1'b0;

      if (m_valid_q && m_axis_tready) begin
         m_valid_d = 1'b0;
      end

      if (accept) begin
         in_frame_d = !s_axis_tlast;
         if (!in_frame_q) begin
            mode_d = ctrl_strip_seq_en;
         end
         if (!strip) begin
            m_valid_d = 1'b1;
            m_data_d  = s_axis_tdata;
            m_last_d  = s_axis_tlast;
         end else begin
            // The held word is released one beat late so the last data word can carry tlast.
            if (hold_valid_q) begin
               m_valid_d = 1'b1;
               m_data_d  = hold_data_q;
               m_last_d  = s_axis_tlast;
            end
            if (!s_axis_tlast) begin
               hold_data_d  = s_axis_tdata;
               hold_valid_d = 1'b1;
            end else begin
               hold_valid_d = 1'b0;
            end
         end
      end

      if (ctrl_rst_cntr_in) begin
         cnt_state_d = CNT_RST;
         seq_state_d = UNSYNC;
         expected_d  = SEQ_INIT;
         seq_last_d  = 16'h0000;
         cntr_d      = 64'd0;
         err_cnt_d   = 32'd0;
      end else if (cnt_state_q == CNT_RST) begin
         cnt_state_d = CNT_COUNT;
      end else if (accept && s_axis_tlast) begin
         cntr_d = cntr_q + 64'd1;
         if (strip) begin
            seq_last_d  = s_axis_tdata[15:0];
            expected_d  = s_axis_tdata[15:0] + 16'd1;
            seq_state_d = SYNC;
            if (seq_state_q == SYNC && s_axis_tdata[15:0] != expected_q) begin
               seq_err_d = 1'b1;
               if (err_cnt_q != 32'hFFFF_FFFF) begin
                  err_cnt_d = err_cnt_q + 32'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         m_valid_q    <= 1'b0;
         m_data_q     <= 32'd0;
         m_last_q     <= 1'b0;
         hold_data_q  <= 32'd0;
         hold_valid_q <= 1'b0;
         in_frame_q   <= 1'b0;
         mode_q       <= 1'b0;
         seq_state_q  <= UNSYNC;
         cnt_state_q  <= CNT_COUNT;
         expected_q   <= SEQ_INIT;
         seq_last_q   <= 16'h0000;
         cntr_q       <= 64'd0;
         err_cnt_q    <= 32'd0;
         seq_err_q    <= 1'b0;
      end else begin
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_last_q     <= m_last_d;
         hold_data_q  <= hold_data_d;
         hold_valid_q <= hold_valid_d;
         in_frame_q   <= in_frame_d;
         mode_q       <= mode_d;
         seq_state_q  <= seq_state_d;
         cnt_state_q  <= cnt_state_d;
         expected_q   <= expected_d;
         seq_last_q   <= seq_last_d;
         cntr_q       <= cntr_d;
         err_cnt_q    <= err_cnt_d;
         seq_err_q    <= seq_err_d;
      end
   end
endmodule
